// File: rtl/equiv_sweep_checker_if.sv
// rtl/equiv_sweep_checker_if.sv - stimulus/observation bundle between sweep checker and its environment
interface equiv_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic [N_IN-1:0]   stim;
    logic              x;
    logic              y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     mism_cnt;
    logic [N_IN-1:0]   first_fail;
    logic              first_valid;

    // checker side: drives the stimulus and reports results
    modport slave (
        input  start,
        input  x,
        input  y,
        output stim,
        output busy,
        output done,
        output pass,
        output mism_cnt,
        output first_fail,
        output first_valid
    );

    // environment side: launches sweeps and returns candidate outputs
    modport master (
        output start,
        output x,
        output y,
        input  stim,
        input  busy,
        input  done,
        input  pass,
        input  mism_cnt,
        input  first_fail,
        input  first_valid
    );
endinterface

// File: rtl/equiv_sweep_checker.sv
// rtl/equiv_sweep_checker.sv - exhaustive stimulus sweeper and X/Y equivalence checker (option: EQUIV_STOP_ON_FAIL_EN)
module equiv_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    equiv_sweep_checker_if.slave   bus
);
    // settle counter only needs to reach SETTLE-1
    localparam int                CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0]   LAST_VEC = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     mism_q, mism_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fv_q, fv_d;
    logic              mismatch;
    logic              stop_on_fail;

    assign mismatch = bus.x ^ bus.y;

`ifdef EQUIV_STOP_ON_FAIL_EN
    assign stop_on_fail = 1'b1;
`else
    assign stop_on_fail = 1'b0;
`endif

    // next-state: sequence vectors, hold each for SETTLE cycles, then compare once
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // restarting from DONE clears the previous results on the same edge
                if (bus.start) begin
                    state_d = S_APPLY;
                    stim_d  = '0;
                    cnt_d   = '0;
                    mism_d  = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                end
            end
            S_APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMPARE: begin
                cnt_d = '0;
                if (mismatch) begin
                    mism_d = mism_q + 1'b1;
                    if (!fv_q) begin
                        ff_d = stim_q;
                        fv_d = 1'b1;
                    end
                end
                // terminal check comes before the increment so STIM never wraps
                if (stop_on_fail && mismatch) begin
                    state_d = S_DONE;
                end else if (stim_q == LAST_VEC) begin
                    state_d = S_DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state register; reset overrides everything including a coincident start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            cnt_q   <= '0;
            mism_q  <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
        end
    end

    assign bus.stim        = stim_q;
    assign bus.busy        = (state_q == S_APPLY) || (state_q == S_COMPARE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.pass        = (state_q == S_DONE) && (mism_q == '0);
    assign bus.mism_cnt    = mism_q;
    assign bus.first_fail  = ff_q;
    assign bus.first_valid = fv_q;
endmodule

// File: tb/tb_equiv_sweep_checker.sv
// tb/tb_equiv_sweep_checker.sv - randomized self-checking bench for equiv_sweep_checker
module tb_equiv_sweep_checker;
    localparam int N_IN   = 2;
    localparam int SETTLE = 1;
    localparam int NV     = 1 << N_IN;
    localparam int VW     = SETTLE + 1;
    localparam int BOUND  = 4 * NV * VW + 20;

    logic clk;
    logic rst;
    logic [NV-1:0] fx_tab;
    logic [NV-1:0] fy_tab;
    int tests;
    int fails;

    equiv_sweep_checker_if #(.N_IN(N_IN)) bus ();

    equiv_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // candidate implementations are truth tables indexed by STIM
    assign bus.x = fx_tab[bus.stim];
    assign bus.y = fy_tab[bus.stim];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference: results follow directly from comparing the two truth tables
    task automatic model(input logic [NV-1:0] fx, input logic [NV-1:0] fy,
                         output int m, output int ff, output bit fv,
                         output int cyc, output int fin);
        m  = 0;
        ff = 0;
        fv = 1'b0;
        for (int v = 0; v < NV; v++) begin
            if (fx[v] != fy[v]) begin
                if (!fv) begin
                    fv = 1'b1;
                    ff = v;
                end
                m++;
            end
        end
`ifdef EQUIV_STOP_ON_FAIL_EN
        if (fv) m = 1;
        cyc = fv ? (ff + 1) * VW : NV * VW;
        fin = fv ? ff : NV - 1;
`else
        cyc = NV * VW;
        fin = NV - 1;
`endif
    endtask

    // pulse start, follow the sweep edge by edge, report cycles to done and trace consistency
    task automatic run_sweep(input int inject_at, input int exp_cyc, input int exp_fin,
                             output int cyc, output bit trace_ok);
        int exp_stim;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        trace_ok = (bus.stim === '0) && (bus.busy === 1'b1) && (bus.done === 1'b0)
                   && (bus.mism_cnt === '0) && (bus.first_valid === 1'b0);
        cyc = -1;
        for (int c = 1; c <= BOUND; c++) begin
            @(posedge clk);
            #1;
            exp_stim = (c < exp_cyc) ? (c / VW) : exp_fin;
            if (bus.stim !== N_IN'(exp_stim)) trace_ok = 1'b0;
            if (bus.busy !== (c < exp_cyc)) trace_ok = 1'b0;
            if (bus.done === 1'b1) begin
                cyc = c;
                break;
            end
            bus.start = (c == inject_at);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.stim !== '0)        begin fails++; $display("FAIL reset_stim: got %0d expected 0", bus.stim); end
        tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        tests++; if (bus.pass !== 1'b0)      begin fails++; $display("FAIL reset_pass: got %0b expected 0", bus.pass); end
        tests++; if (bus.mism_cnt !== '0)    begin fails++; $display("FAIL reset_mism: got %0d expected 0", bus.mism_cnt); end
        tests++; if (bus.first_fail !== '0)  begin fails++; $display("FAIL reset_ff: got %0d expected 0", bus.first_fail); end
        tests++; if (bus.first_valid !== 1'b0) begin fails++; $display("FAIL reset_fv: got %0b expected 0", bus.first_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // run one sweep on the given tables and compare every result against the model
    task automatic test_sweep(input string name, input logic [NV-1:0] fx, input logic [NV-1:0] fy,
                              input int inject_at);
        int m, ff, cyc, fin, got_cyc;
        bit fv, tr;
        fx_tab = fx;
        fy_tab = fy;
        model(fx, fy, m, ff, fv, cyc, fin);
        run_sweep(inject_at, cyc, fin, got_cyc, tr);
        tests++; if (got_cyc != cyc) begin fails++; $display("FAIL %s_cycles: got %0d expected %0d", name, got_cyc, cyc); end
        tests++; if (tr !== 1'b1) begin fails++; $display("FAIL %s_trace: got %0b expected 1", name, tr); end
        tests++; if (bus.pass !== (m == 0)) begin fails++; $display("FAIL %s_pass: got %0b expected %0b", name, bus.pass, (m == 0)); end
        tests++; if (bus.mism_cnt !== (N_IN+1)'(m)) begin fails++; $display("FAIL %s_mism: got %0d expected %0d", name, bus.mism_cnt, m); end
        tests++; if (bus.first_valid !== fv) begin fails++; $display("FAIL %s_fv: got %0b expected %0b", name, bus.first_valid, fv); end
        if (fv) begin
            tests++; if (bus.first_fail !== N_IN'(ff)) begin fails++; $display("FAIL %s_ff: got %0d expected %0d", name, bus.first_fail, ff); end
        end
        tests++; if (bus.stim !== N_IN'(fin)) begin fails++; $display("FAIL %s_final_stim: got %0d expected %0d", name, bus.stim, fin); end
    endtask

    task automatic test_equal_xor();
        test_sweep("xor_equal", 4'b0110, 4'b0110, 0);
    endtask

    task automatic test_single_mismatch();
        test_sweep("single_mism", 4'b0110, 4'b0110 ^ 4'b0100, 0);
    endtask

    task automatic test_all_mismatch();
        test_sweep("all_mism", 4'b0110, ~4'b0110, 0);
    endtask

    task automatic test_stop_case();
        test_sweep("mism_at_01", 4'b0110, 4'b0110 ^ 4'b0010, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            test_sweep("random", NV'($urandom), NV'($urandom), 0);
        end
    endtask

    task automatic test_start_while_busy();
        test_sweep("start_busy", 4'b1001, 4'b1011, 3);
    endtask

    task automatic test_back_to_back();
        test_sweep("b2b_first", 4'b1100, 4'b0011, 0);
        test_sweep("b2b_second", 4'b1010, 4'b1010, 0);
    endtask

    task automatic test_mid_reset();
        fx_tab = 4'b0000;
        fy_tab = 4'b1111;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        // reset and start together: reset must win
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b expected 0", bus.busy); end
        tests++; if (bus.stim !== '0) begin fails++; $display("FAIL midrst_stim: got %0d expected 0", bus.stim); end
        tests++; if (bus.mism_cnt !== '0) begin fails++; $display("FAIL midrst_mism: got %0d expected 0", bus.mism_cnt); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %0b expected 0", bus.done); end
        tests++; if (bus.first_valid !== 1'b0) begin fails++; $display("FAIL midrst_fv: got %0b expected 0", bus.first_valid); end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_start_dropped: got busy %0b expected 0", bus.busy); end
        test_sweep("after_rst", 4'b0110, 4'b0110, 0);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        fx_tab    = '0;
        fy_tab    = '0;
        test_reset();
        test_equal_xor();
        test_single_mismatch();
        test_all_mismatch();
        test_stop_case();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
